// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: registered position, sync, blanking and frame outputs.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN; otherwise frame is tied to 0.
module vga_sync_gen #(
    parameter int H_VIEW     = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VIEW     = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int FCW        = 8,
    localparam int H_TOTAL   = H_VIEW + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL   = V_VIEW + V_FRONT + V_SYNC + V_BACK,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    output logic [HW-1:0]  hpos,
    output logic [VW-1:0]  vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           hmax,
    output logic           vmax,
    output logic           hblank,
    output logic           vblank,
    output logic           visible,
    output logic           frame_start,
    output logic [FCW-1:0] frame
);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_E = HW'(H_VIEW);
    localparam logic [VW-1:0] V_VIS_E = VW'(V_VIEW);
    localparam logic [HW-1:0] H_SYN_S = HW'(H_VIEW + H_FRONT);
    localparam logic [HW-1:0] H_SYN_E = HW'(H_VIEW + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_SYN_S = VW'(V_VIEW + V_FRONT);
    localparam logic [VW-1:0] V_SYN_E = VW'(V_VIEW + V_FRONT + V_SYNC);

`ifndef SYNTHESIS
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_param_chk
        $error("vga_sync_gen: every porch and sync width must be >= 1");
    end
`endif

    logic [HW-1:0] r_hpos;
    logic [VW-1:0] r_vpos;
    logic          r_hsync, r_vsync, r_hmax, r_vmax;
    logic          r_hblank, r_vblank, r_visible, r_frame_start;

    logic          w_hlast, w_vlast, w_wrap;
    logic [HW-1:0] w_hnext;
    logic [VW-1:0] w_vnext;
    logic          w_hsync_act, w_vsync_act;

    // Outputs are decoded from the next position so they stay aligned with hpos/vpos.
    always_comb begin
        w_hlast     = (r_hpos == H_LAST);
        w_vlast     = (r_vpos == V_LAST);
        w_hnext     = w_hlast ? '0 : r_hpos + 1'b1;
        w_vnext     = r_vpos;
        if (w_hlast)
            w_vnext = w_vlast ? '0 : r_vpos + 1'b1;
        w_wrap      = w_hlast && w_vlast;
        w_hsync_act = (w_hnext >= H_SYN_S) && (w_hnext < H_SYN_E);
        w_vsync_act = (w_vnext >= V_SYN_S) && (w_vnext < V_SYN_E);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hmax        <= 1'b1;
            r_vmax        <= 1'b1;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_visible     <= 1'b0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (clk_en) begin
                r_hpos        <= w_hnext;
                r_vpos        <= w_vnext;
                r_hmax        <= (w_hnext == H_LAST);
                r_vmax        <= (w_vnext == V_LAST);
                r_hblank      <= (w_hnext >= H_VIS_E);
                r_vblank      <= (w_vnext >= V_VIS_E);
                r_visible     <= (w_hnext < H_VIS_E) && (w_vnext < V_VIS_E);
                r_hsync       <= w_hsync_act ? H_SYNC_POL : ~H_SYNC_POL;
                r_vsync       <= w_vsync_act ? V_SYNC_POL : ~V_SYNC_POL;
                r_frame_start <= w_wrap;
            end
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [FCW-1:0] r_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_frame <= '0;
        else if (clk_en && w_wrap)
            r_frame <= r_frame + 1'b1;
    end

    assign frame = r_frame;
`else
    assign frame = '0;
`endif

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hmax        = r_hmax;
    assign vmax        = r_vmax;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign visible     = r_visible;
    assign frame_start = r_frame_start;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL provide parameters: H_VIEW=640, H_FRONT=16, H_SYNC=96, H_BACK=48, V_VIEW=480, V_FRONT=10, V_SYNC=2, V_BACK=33.
REQ-002 SHALL provide parameters: H_SYNC_POL=0 and V_SYNC_POL=0 (sync active level; 0 = active-low), and FCW=8 (frame counter width).
REQ-003 SHALL derive H_TOTAL = sum of the four H parameters and V_TOTAL likewise; HW = clog2(H_TOTAL), VW = clog2(V_TOTAL).
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  pixel step enable (divider strobe).
- hpos  out  HW  horizontal position.
- vpos  out  VW  vertical position.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- hmax  out  1  last pixel of line.
- vmax  out  1  last line of frame.
- hblank  out  1  horizontal blanking.
- vblank  out  1  vertical blanking.
- visible  out  1  active display area.
- frame_start  out  1  one-clk pulse on new frame.
- frame  out  FCW  frame count.

Function
REQ-005 On each clk edge with clk_en=1: hpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-006 With clk_en=0, all outputs SHALL hold their values; frame_start SHALL be 0.
REQ-007 All outputs SHALL be registers, consistent in the same cycle with hpos/vpos; there SHALL be no combinational path from clk_en to any output.
REQ-008 hmax SHALL be 1 iff hpos==H_TOTAL-1; vmax SHALL be 1 iff vpos==V_TOTAL-1.
REQ-009 hblank SHALL be 1 iff hpos>=H_VIEW; vblank SHALL be 1 iff vpos>=V_VIEW; visible SHALL equal !hblank && !vblank.
REQ-010 hsync SHALL be at active level H_SYNC_POL iff H_VIEW+H_FRONT <= hpos < H_VIEW+H_FRONT+H_SYNC; otherwise it SHALL be at !H_SYNC_POL.
REQ-011 vsync SHALL follow the same rule on vpos with the V_* parameters and V_SYNC_POL, independent of hpos.
REQ-012 frame_start SHALL be 1 for exactly one clk cycle after each clk_en step that moves the position to (0,0).
REQ-013 frame SHALL increment modulo 2^FCW on the same step that asserts frame_start.
REQ-014 Each porch and sync parameter SHALL be >=1; violation SHALL be flagged by an elaboration-time check, which SHALL be ignored in synthesis.

Reset
REQ-015 rst_n=0 SHALL asynchronously force hpos=H_TOTAL-1, vpos=V_TOTAL-1, hmax=1, vmax=1, hblank=1, vblank=1, visible=0, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, frame_start=0, frame=0.
REQ-016 After rst_n deasserts, the first clk_en step SHALL move the position to (0,0), assert frame_start, and set frame=1.
REQ-017 Reset mid-frame SHALL abandon the frame immediately and restart per REQ-015/016; no partial-line state SHALL persist.

Configuration
REQ-018 Macro VGA_FRAME_COUNTER_EN: when defined, frame SHALL count per REQ-013.
REQ-019 When VGA_FRAME_COUNTER_EN is undefined, the frame port SHALL remain present, tied to 0 with no counter flops; all other behaviour SHALL be unchanged.

Verification
REQ-020 Defaults, clk_en=1, release reset: 1st clk -> hpos=0, vpos=0, visible=1, frame_start=1; 800*525 clks later -> frame_start=1 again, frame=2 (macro on) or 0 (macro off).
REQ-021 Defaults: line of vpos=0 -> hsync=0 exactly for hpos 656..751 (96 clks); hblank=1 for hpos 640..799; hmax=1 only at hpos=799.
REQ-022 Defaults: vsync=0 exactly for vpos 490..491; vblank=1 for vpos 480..524; vmax=1 only at vpos=524; visible=0 throughout vblank.
REQ-023 clk_en asserted 1 clk in 4 -> position advances once per 4 clks; frame_start width = 1 clk; outputs frozen between strobes.
REQ-024 Minimal params (all H=1 except H_VIEW=4, V_VIEW=3, H_SYNC_POL=1) -> H_TOTAL=7, V_TOTAL=6; hsync=1 only at hpos=5; frame wraps 255->0 after 256 frames.
REQ-025 Assert rst_n=0 at hpos=300, vpos=200 -> outputs immediately take REQ-015 values without a clk edge; next clk_en step -> (0,0), frame_start=1.
